ntt_sequencer: RTL and testbench

NTT_SEQUENCER -- requirements
Module: ntt_sequencer

---
 rtl/ntt_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_ntt_sequencer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_sequencer.sv
// ntt_sequencer
// Feeds one transform's worth of 60-bit coefficient words into an NTT
// processor's memory, kicks the processor, then watches its output burst
// and reports completion or failure.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready   coefficient word handshake, s_data carries the word
//   clear             leaves the sticky error state (ignored elsewhere)
//   proc_we/addr/data registered write port into the processor memory
//   proc_start        one-cycle start pulse to the processor
//   proc_ready        processor standby, gates acceptance of a new job
//   proc_out_active   processor output burst indicator
//   busy              job in progress (not IDLE, not ERR)
//   done              one-cycle pulse when a transform completes cleanly
//   err               sticky error flag (ERR state)
//   beat_idx          index of the current output beat
module ntt_sequencer #(
   parameter int WORDS     = 2048,
   parameter int OUT_BEATS = 64,
   parameter int TIMEOUT   = 8192
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [59:0] s_data,
   input  logic        clear,
   output logic        proc_we,
   output logic [10:0] proc_addr,
   output logic [59:0] proc_data,
   output logic        proc_start,
   input  logic        proc_ready,
   input  logic        proc_out_active,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [6:0]  beat_idx
);

   localparam int CW = 12;                    // holds 0..2048
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_KICK, S_RUN, S_DRAIN, S_FIN, S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      en_q, en_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [6:0]      beat_q, beat_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            we_q, we_d;
   logic [10:0]     addr_q, addr_d;
   logic [59:0]     data_q, data_d;
   logic            start_q, start_d;

   logic            run_en;
   logic            hs;
   logic [TW-1:0]   tmo_inc;
   logic [6:0]      beat_sat;

   // Reset release is passed through two flops so that nothing moves until
   // the second rising edge after rst_n goes high.
   assign run_en   = en_q[1];
   assign hs       = s_valid & s_ready;
   assign tmo_inc  = tmo_q + TW'(1);
   // Saturate so an overlong burst can never wrap back onto OUT_BEATS.
   assign beat_sat = (beat_q == 7'h7f) ? beat_q : beat_q + 7'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         en_q    <= '0;
         cnt_q   <= '0;
         beat_q  <= '0;
         tmo_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
         tmo_q   <= tmo_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         start_q <= start_d;
      end
   end

   always_comb begin
      en_d    = {en_q[0], 1'b1};
      state_d = state_q;
      cnt_d   = cnt_q;
      beat_d  = beat_q;
      tmo_d   = tmo_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      start_d = 1'b0;
      if (run_en) begin
         case (state_q)
            S_IDLE: begin
               if (hs) begin
                  we_d    = 1'b1;
                  addr_d  = '0;
                  data_d  = s_data;
                  cnt_d   = CW'(1);
                  state_d = (WORDS == 1) ? S_KICK : S_LOAD;
               end
            end
            S_LOAD: begin
               if (hs) begin
                  we_d   = 1'b1;
                  addr_d = cnt_q[10:0];
                  data_d = s_data;
                  cnt_d  = cnt_q + CW'(1);
                  if (cnt_q == CW'(WORDS - 1)) state_d = S_KICK;
               end
            end
            S_KICK: begin
               // Start is registered, so it lands one cycle after the final
               // write strobe and never overlaps it.
               start_d = 1'b1;
               tmo_d   = '0;
               beat_d  = '0;
               state_d = S_RUN;
            end
            S_RUN: begin
               tmo_d = tmo_inc;
               if (tmo_inc == TW'(TIMEOUT)) begin
                  state_d = S_ERR;
               end else if (proc_out_active) begin
                  // The first beat is seen here, so it is counted here.
                  beat_d  = beat_sat;
                  state_d = S_DRAIN;
               end
            end
            S_DRAIN: begin
               tmo_d = tmo_inc;
               if (tmo_inc == TW'(TIMEOUT)) begin
                  state_d = S_ERR;
               end else if (proc_out_active) begin
                  beat_d = beat_sat;
               end else if (beat_q == 7'(OUT_BEATS)) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_FIN: begin
               cnt_d   = '0;
               beat_d  = '0;
               tmo_d   = '0;
               state_d = S_IDLE;
            end
            S_ERR: begin
               if (clear) begin
                  cnt_d   = '0;
                  beat_d  = '0;
                  tmo_d   = '0;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      s_ready = 1'b0;
      case (state_q)
         // Held off until the reset synchroniser releases, so no word can be
         // offered and then silently dropped.
         S_IDLE:  s_ready = proc_ready & run_en;
         S_LOAD:  s_ready = 1'b1;
         default: s_ready = 1'b0;
      endcase
   end

   assign proc_we    = we_q;
   assign proc_addr  = addr_q;
   assign proc_data  = data_q;
   assign proc_start = start_q;
   assign busy       = (state_q != S_IDLE) && (state_q != S_ERR);
   assign done       = (state_q == S_FIN);
   assign err        = (state_q == S_ERR);
   assign beat_idx   = beat_q;

endmodule

// File: tb/tb_ntt_sequencer.sv
// Testbench for ntt_sequencer: random coefficient streams and a simple
// processor model; a negedge monitor logs activity, tasks compare the logs
// against expectations derived from the required behaviour.
module tb_ntt_sequencer;

   localparam int WORDS     = 2048;
   localparam int OUT_BEATS = 64;
   localparam int TIMEOUT   = 8192;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic [59:0] s_data = '0;
   logic        clear = 1'b0;
   logic        proc_ready = 1'b0;
   logic        proc_out_active = 1'b0;
   logic        s_ready, proc_we, proc_start, busy, done, err;
   logic [10:0] proc_addr;
   logic [59:0] proc_data;
   logic [6:0]  beat_idx;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [59:0] hs_data_q[$];
   int          hs_cyc_q[$];
   logic [10:0] wr_addr_q[$];
   logic [59:0] wr_data_q[$];
   int          wr_cyc_q[$];
   int          start_cyc_q[$];
   int          done_cyc_q[$];
   int          beat_log[$];
   int          err_cyc = -1;
   int          overlap_cnt = 0;
   int          fall_cyc = -1;

   ntt_sequencer #(.WORDS(WORDS), .OUT_BEATS(OUT_BEATS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .clear(clear), .proc_we(proc_we), .proc_addr(proc_addr),
      .proc_data(proc_data), .proc_start(proc_start), .proc_ready(proc_ready),
      .proc_out_active(proc_out_active), .busy(busy), .done(done), .err(err),
      .beat_idx(beat_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Activity logger only; no judgement is made here.
   always @(negedge clk) begin
      if (rst_n) begin
         if (s_valid && s_ready) begin
            hs_data_q.push_back(s_data);
            hs_cyc_q.push_back(cyc);
         end
         if (proc_we) begin
            wr_addr_q.push_back(proc_addr);
            wr_data_q.push_back(proc_data);
            wr_cyc_q.push_back(cyc);
         end
         if (proc_start) start_cyc_q.push_back(cyc);
         if (proc_start && proc_we) overlap_cnt++;
         if (done) done_cyc_q.push_back(cyc);
         if (proc_out_active) beat_log.push_back(int'(beat_idx));
         if (err && err_cyc < 0) err_cyc = cyc;
      end
   end

   function automatic logic [59:0] rand60();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[59:0];
   endfunction

   // Index of the first write that is not the i-th accepted word at address i,
   // one cycle after its handshake; -1 when every logged write is right.
   function automatic int first_wr_mismatch();
      int n;
      n = (wr_addr_q.size() < hs_data_q.size()) ? wr_addr_q.size() : hs_data_q.size();
      for (int i = 0; i < n; i++)
         if (wr_addr_q[i] !== 11'(i) || wr_data_q[i] !== hs_data_q[i] ||
             wr_cyc_q[i] != hs_cyc_q[i] + 1) return i;
      return -1;
   endfunction

   function automatic int first_beat_mismatch();
      for (int i = 0; i < beat_log.size(); i++)
         if (beat_log[i] != i) return i;
      return -1;
   endfunction

   function automatic int last_hs_cyc();
      if (hs_cyc_q.size() == 0) return -100;
      return hs_cyc_q[hs_cyc_q.size() - 1];
   endfunction

   task automatic clear_logs();
      hs_data_q.delete(); hs_cyc_q.delete();
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      start_cyc_q.delete(); done_cyc_q.delete(); beat_log.delete();
      err_cyc = -1; overlap_cnt = 0; fall_cyc = -1;
   endtask

   // mode 0: valid every cycle, 1: valid every other cycle, 2: random stalls
   // plus stray clear pulses. Stops once 'limit' words have been accepted.
   task automatic load_words(input int mode, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk); #1;
         if (hs_data_q.size() >= limit) begin
            ok = 1'b1;
            break;
         end
         case (mode)
            0:       s_valid = 1'b1;
            1:       s_valid = (i % 2 == 0);
            default: s_valid = ($urandom_range(0, 3) != 0);
         endcase
         clear  = (mode == 2) && ($urandom_range(0, 15) == 0);
         s_data = rand60();
      end
      s_valid = 1'b0;
      clear   = 1'b0;
   endtask

   // Waits for the start pulse, idles a random while, then holds
   // proc_out_active for 'beats' cycles.
   task automatic proc_model(input int beats, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (start_cyc_q.size() > 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         repeat ($urandom_range(0, 20)) @(posedge clk);
         #1;
         proc_out_active = 1'b1;
         repeat (beats) begin
            @(posedge clk); #1;
         end
         proc_out_active = 1'b0;
         fall_cyc = cyc;
      end
   endtask

   task automatic wait_end(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < TIMEOUT + 300; i++) begin
         @(posedge clk); #1;
         if (done_cyc_q.size() > 0 || err_cyc >= 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      proc_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({proc_we, proc_start, done, err, busy} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags got we=%b start=%b done=%b err=%b busy=%b want all 0",
                  proc_we, proc_start, done, err, busy);
      end
      total++;
      if (proc_addr !== 11'd0 || proc_data !== 60'd0 || beat_idx !== 7'd0) begin
         bad++;
         $display("FAIL reset_values got addr=%0d data=%h beat=%0d want 0",
                  proc_addr, proc_data, beat_idx);
      end
      rst_n   = 1'b1;
      s_valid = 1'b1;
      s_data  = rand60();
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || proc_we !== 1'b0) begin
         bad++;
         $display("FAIL reset_sync got busy=%b we=%b after first edge want 0", busy, proc_we);
      end
      s_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      proc_ready = 1'b0; #1;
      total++;
      if (s_ready !== 1'b0) begin
         bad++;
         $display("FAIL idle_ready_lo got s_ready=%b want 0", s_ready);
      end
      proc_ready = 1'b1; #1;
      total++;
      if (s_ready !== 1'b1) begin
         bad++;
         $display("FAIL idle_ready_hi got s_ready=%b want 1", s_ready);
      end
      clear_logs();
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2, ok3;
      int idx;
      clear_logs();
      load_words(0, WORDS, ok1);
      proc_model(OUT_BEATS, ok2);
      wait_end(ok3);
      total++;
      if (!(ok1 && ok2 && ok3)) begin
         bad++;
         $display("FAIL b2b_progress got load=%0b start=%0b end=%0b want 111", ok1, ok2, ok3);
      end
      total++;
      if (wr_addr_q.size() != WORDS) begin
         bad++;
         $display("FAIL b2b_wr_count got %0d want %0d", wr_addr_q.size(), WORDS);
      end
      idx = first_wr_mismatch();
      total++;
      if (idx >= 0) begin
         bad++;
         $display("FAIL b2b_write[%0d] got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                  idx, wr_addr_q[idx], wr_data_q[idx], wr_cyc_q[idx], idx, hs_data_q[idx],
                  hs_cyc_q[idx] + 1);
      end
      total++;
      if (start_cyc_q.size() != 1 || start_cyc_q[0] != last_hs_cyc() + 2) begin
         bad++;
         $display("FAIL b2b_start got pulses=%0d first_cyc=%0d want 1 at %0d",
                  start_cyc_q.size(), (start_cyc_q.size() > 0) ? start_cyc_q[0] : -1,
                  last_hs_cyc() + 2);
      end
      idx = first_beat_mismatch();
      total++;
      if (beat_log.size() != OUT_BEATS || idx >= 0) begin
         bad++;
         $display("FAIL b2b_beats got count=%0d first_bad=%0d want count=%0d indices 0..%0d",
                  beat_log.size(), idx, OUT_BEATS, OUT_BEATS - 1);
      end
      total++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] != fall_cyc + 1) begin
         bad++;
         $display("FAIL b2b_done got pulses=%0d cyc=%0d want 1 at %0d", done_cyc_q.size(),
                  (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, fall_cyc + 1);
      end
      total++;
      if (err_cyc >= 0 || overlap_cnt != 0) begin
         bad++;
         $display("FAIL b2b_err got err_cyc=%0d overlap=%0d want none", err_cyc, overlap_cnt);
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || s_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_idle got busy=%b s_ready=%b want busy=0 s_ready=1", busy, s_ready);
      end
   endtask

   task automatic test_toggle();
      bit ok1, ok2, ok3;
      int idx, dur;
      clear_logs();
      load_words(1, WORDS, ok1);
      proc_model(OUT_BEATS, ok2);
      wait_end(ok3);
      total++;
      if (!(ok1 && ok2 && ok3) || wr_addr_q.size() != WORDS) begin
         bad++;
         $display("FAIL tog_progress got load=%0b start=%0b end=%0b writes=%0d want 111 and %0d",
                  ok1, ok2, ok3, wr_addr_q.size(), WORDS);
      end
      idx = first_wr_mismatch();
      total++;
      if (idx >= 0) begin
         bad++;
         $display("FAIL tog_write[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                  idx, wr_addr_q[idx], wr_data_q[idx], idx, hs_data_q[idx]);
      end
      dur = (hs_cyc_q.size() > 0) ? last_hs_cyc() - hs_cyc_q[0] + 1 : -1;
      total++;
      if (dur != 2 * WORDS - 1) begin
         bad++;
         $display("FAIL tog_duration got %0d cycles want %0d", dur, 2 * WORDS - 1);
      end
      total++;
      if (done_cyc_q.size() != 1 || err_cyc >= 0) begin
         bad++;
         $display("FAIL tog_done got pulses=%0d err_cyc=%0d want 1 and none",
                  done_cyc_q.size(), err_cyc);
      end
   endtask

   task automatic test_short_burst();
      bit ok1, ok2, ok3;
      int idx;
      clear_logs();
      load_words(2, WORDS, ok1);
      proc_model(OUT_BEATS - 1, ok2);
      wait_end(ok3);
      total++;
      if (!(ok1 && ok2 && ok3) || wr_addr_q.size() != WORDS) begin
         bad++;
         $display("FAIL short_progress got load=%0b start=%0b end=%0b writes=%0d want 111 and %0d",
                  ok1, ok2, ok3, wr_addr_q.size(), WORDS);
      end
      idx = first_wr_mismatch();
      total++;
      if (idx >= 0) begin
         bad++;
         $display("FAIL short_write[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                  idx, wr_addr_q[idx], wr_data_q[idx], idx, hs_data_q[idx]);
      end
      total++;
      if (err_cyc != fall_cyc + 1) begin
         bad++;
         $display("FAIL short_err_time got %0d want %0d", err_cyc, fall_cyc + 1);
      end
      proc_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || done_cyc_q.size() != 0) begin
         bad++;
         $display("FAIL short_sticky got err=%b busy=%b s_ready=%b done=%0d want 1 0 0 0",
                  err, busy, s_ready, done_cyc_q.size());
      end
      clear   = 1'b1;
      s_valid = 1'b1;
      s_data  = rand60();
      @(posedge clk); #1;
      clear      = 1'b0;
      s_valid    = 1'b0;
      proc_ready = 1'b0;
      #1;
      total++;
      if (err !== 1'b0 || busy !== 1'b0 || proc_we !== 1'b0 || s_ready !== 1'b0) begin
         bad++;
         $display("FAIL short_clear got err=%b busy=%b we=%b s_ready=%b want 0 0 0 0",
                  err, busy, proc_we, s_ready);
      end
      proc_ready = 1'b1; #1;
      total++;
      if (s_ready !== 1'b1 || hs_data_q.size() != WORDS) begin
         bad++;
         $display("FAIL short_after_clear got s_ready=%b accepted=%0d want 1 and %0d",
                  s_ready, hs_data_q.size(), WORDS);
      end
   endtask

   task automatic test_timeout();
      bit ok1, ok3;
      clear_logs();
      load_words(0, WORDS, ok1);
      wait_end(ok3);
      total++;
      if (!(ok1 && ok3) || start_cyc_q.size() != 1 ||
          err_cyc - start_cyc_q[0] != TIMEOUT) begin
         bad++;
         $display("FAIL timeout got load=%0b end=%0b starts=%0d err_cyc=%0d want err %0d after start",
                  ok1, ok3, start_cyc_q.size(), err_cyc, TIMEOUT);
      end
      total++;
      if (done_cyc_q.size() != 0 || err !== 1'b1) begin
         bad++;
         $display("FAIL timeout_state got done=%0d err=%b want 0 and 1", done_cyc_q.size(), err);
      end
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL timeout_clear got err=%b busy=%b want 0 0", err, busy);
      end
   endtask

   task automatic test_reset_mid_load();
      bit ok1, ok2, ok3;
      int idx;
      clear_logs();
      load_words(0, 1000, ok1);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (!ok1 || {proc_we, proc_start, done, err, busy} !== 5'b0 ||
          proc_addr !== 11'd0 || proc_data !== 60'd0 || beat_idx !== 7'd0) begin
         bad++;
         $display("FAIL midreset_outputs got load=%0b we=%b start=%b done=%b err=%b busy=%b addr=%0d data=%h beat=%0d want all 0",
                  ok1, proc_we, proc_start, done, err, busy, proc_addr, proc_data, beat_idx);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      clear_logs();
      load_words(0, WORDS, ok1);
      proc_model(OUT_BEATS, ok2);
      wait_end(ok3);
      total++;
      if (wr_addr_q.size() != WORDS || wr_addr_q[0] !== 11'd0) begin
         bad++;
         $display("FAIL midreset_restart got writes=%0d first_addr=%0d want %0d from 0",
                  wr_addr_q.size(), (wr_addr_q.size() > 0) ? int'(wr_addr_q[0]) : -1, WORDS);
      end
      idx = first_wr_mismatch();
      total++;
      if (idx >= 0 || !(ok1 && ok2 && ok3) || done_cyc_q.size() != 1) begin
         bad++;
         $display("FAIL midreset_job got first_bad=%0d progress=%0b%0b%0b done=%0d want -1 111 1",
                  idx, ok1, ok2, ok3, done_cyc_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_toggle();
      test_short_burst();
      test_timeout();
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog simulation did not finish within 5 ms");
      $fatal(1, "watchdog");
   end

endmodule
